// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline.
// Handles operand forwarding selects, load/branch/HI-LO interlocks and the
// fetch/decode flush. It also contains the multiply busy sequencer and a
// counter of stalled cycles.
module hazard_ctrl #(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic             branchD,
  input  logic             jumpD,
  input  logic             pc_srcD,
  input  logic             mfhiloD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeregE,
  input  logic             we_regE,
  input  logic             dm2regE,
  input  logic             mult_startE,
  input  logic [4:0]       writeregM,
  input  logic             we_regM,
  input  logic             dm2regM,
  input  logic [4:0]       writeregW,
  input  logic             we_regW,
  input  logic             cnt_clr,
  output logic [1:0]       fwdAE,
  output logic [1:0]       fwdBE,
  output logic             fwdAD,
  output logic             fwdBD,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic             mult_busy,
  output logic             mult_done,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mult_state_e;

  localparam logic [3:0]       LAT_M1  = 4'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // A pipeline stage produces register r; $0 is hard-wired and never produced.
  function automatic logic match_f(input logic we, input logic [4:0] wr,
                                   input logic [4:0] r);
    return we && (wr != 5'd0) && (wr == r);
  endfunction

  mult_state_e            state_r, state_s;
  logic [3:0]             cnt_r, cnt_s;
  logic [CNT_W-1:0]       stall_cnt_r;
  logic                   lwstall_s, brstall_s, mdstall_s, stall_s;

  // Multiply sequencer next state: a new multiply always restarts the count.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (mult_startE) begin
          state_s = BUSY;
          cnt_s   = LAT_M1;
        end else begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end
      end
      BUSY: begin
        if (mult_startE) begin
          state_s = BUSY;
          cnt_s   = LAT_M1;
        end else if (cnt_r > 4'd1) begin
          state_s = BUSY;
          cnt_s   = cnt_r - 4'd1;
        end else begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Multiply sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Busy/done decode from the registered sequencer state; a restart in the
  // final cycle cancels the completion pulse.
  always_comb begin
    mult_busy = (state_r == BUSY);
    if ((state_r == BUSY) && (cnt_r == 4'd1) && !mult_startE) begin
      mult_done = 1'b1;
    end else begin
      mult_done = 1'b0;
    end
  end

  // Interlock detection and forwarding selects, all forced idle during reset.
  always_comb begin
    lwstall_s = 1'b0;
    brstall_s = 1'b0;
    mdstall_s = 1'b0;
    stall_s   = 1'b0;
    fwdAE     = 2'b00;
    fwdBE     = 2'b00;
    fwdAD     = 1'b0;
    fwdBD     = 1'b0;
    flushD    = 1'b0;
    if (rst) begin
      stall_s = 1'b0;
    end else begin
      lwstall_s = dm2regE && (match_f(we_regE, writeregE, rsD) ||
                              match_f(we_regE, writeregE, rtD));
      brstall_s = branchD && (match_f(we_regE, writeregE, rsD) ||
                              match_f(we_regE, writeregE, rtD) ||
                              (dm2regM && (match_f(we_regM, writeregM, rsD) ||
                                           match_f(we_regM, writeregM, rtD))));
      mdstall_s = mfhiloD && (mult_busy || mult_startE);
      stall_s   = lwstall_s || brstall_s || mdstall_s;

      if (match_f(we_regM, writeregM, rsE)) begin
        fwdAE = 2'b10;
      end else if (match_f(we_regW, writeregW, rsE)) begin
        fwdAE = 2'b01;
      end else begin
        fwdAE = 2'b00;
      end

      if (match_f(we_regM, writeregM, rtE)) begin
        fwdBE = 2'b10;
      end else if (match_f(we_regW, writeregW, rtE)) begin
        fwdBE = 2'b01;
      end else begin
        fwdBE = 2'b00;
      end

      fwdAD  = match_f(we_regM, writeregM, rsD);
      fwdBD  = match_f(we_regM, writeregM, rtD);
      // A stalled branch has not resolved yet, so it must not flush.
      flushD = (pc_srcD || jumpD) && !stall_s;
    end
    stallF = stall_s;
    stallD = stall_s;
    flushE = stall_s;
  end

  // Saturating count of stalled cycles; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;

endmodule
